// File: rtl/llc_pkg.sv
// Shared LLC types: set index, channel identifiers and the transaction stage encoding.
package llc_pkg;

    localparam int unsigned LLC_SET_BITS = 9;
    localparam int unsigned LLC_WAY_BITS = 4;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;

    localparam int unsigned CH_RSP = 0;
    localparam int unsigned CH_RST = 1;
    localparam int unsigned CH_REQ = 2;
    localparam int unsigned CH_DMA = 3;

    typedef enum logic [2:0] {
        ST_DECODE   = 3'd0,
        ST_READ_SET = 3'd1,
        ST_READ_MEM = 3'd2,
        ST_LOOKUP   = 3'd3,
        ST_PROCESS  = 3'd4,
        ST_UPDATE   = 3'd5
    } llc_stage_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/llc_txn_sequencer_if.sv
// Channel handshake, stage enables and status bundle of the LLC transaction sequencer.
interface llc_txn_sequencer_if
    import llc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SET_W  = LLC_SET_BITS,
    parameter int unsigned CH_W   = idx_w(NUM_CH)
);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0][SET_W-1:0] in_set;
    logic [NUM_CH-1:0]            stall_mask;
    logic                         rr_mode;
    logic                         process_done;
    logic [NUM_CH-1:0]            in_ready;
    logic [CH_W-1:0]              grant_ch;
    logic [SET_W-1:0]             set_out;
    logic                         decode_en;
    logic                         rd_set_en;
    logic                         rd_mem_en;
    logic                         lookup_en;
    logic                         process_en;
    logic                         update_en;
    logic                         abort;
    logic                         err_timeout;
    logic [31:0]                  txn_cnt;

    modport master (
        output in_valid, in_set, stall_mask, rr_mode, process_done,
        input  in_ready, grant_ch, set_out, decode_en, rd_set_en, rd_mem_en,
               lookup_en, process_en, update_en, abort, err_timeout, txn_cnt
    );

    modport slave (
        input  in_valid, in_set, stall_mask, rr_mode, process_done,
        output in_ready, grant_ch, set_out, decode_en, rd_set_en, rd_mem_en,
               lookup_en, process_en, update_en, abort, err_timeout, txn_cnt
    );

endinterface

// File: rtl/llc_rr_arbiter.sv
// N-way arbiter: channel 0 always first, then fixed priority or round-robin over 1..N-1.
module llc_rr_arbiter
    import llc_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          rr_mode,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] rr_ptr;
    logic          found;
    int unsigned   cand;

    assign any = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        if (req[IW'(CH_RSP)]) begin
            grant_idx = IW'(CH_RSP);
            found     = 1'b1;
        end else if (!rr_mode) begin
            for (int i = 1; i < N; i++) begin
                if (req[IW'(i)] && !found) begin
                    grant_idx = IW'(i);
                    found     = 1'b1;
                end
            end
        end else begin
            // Circular search over 1..N-1 starting at rr_ptr.
            for (int off = 0; off < N - 1; off++) begin
                cand = ((32'(rr_ptr) - 32'd1 + 32'(off)) % (N - 1)) + 32'd1;
                if (req[IW'(cand)] && !found) begin
                    grant_idx = IW'(cand);
                    found     = 1'b1;
                end
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= IW'(1);
        end else if (advance && rr_mode && grant_idx != IW'(CH_RSP)) begin
            rr_ptr <= (grant_idx == IW'(N - 1)) ? IW'(1) : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/llc_txn_sequencer.sv
// LLC transaction sequencer: arbitrates channels and steps each transaction through the stage pipeline.
module llc_txn_sequencer
    import llc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SET_W  = LLC_SET_BITS,
    parameter int unsigned WD_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    llc_txn_sequencer_if.slave  bus
);

    localparam int unsigned CH_W = idx_w(NUM_CH);
    localparam int unsigned RD_W = idx_w(RD_LAT);
    localparam logic [WD_W-1:0] WD_LAST = {{(WD_W-1){1'b1}}, 1'b0};

    llc_stage_t        state;
    logic [RD_W-1:0]   rd_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [CH_W-1:0]   grant_q;
    logic [SET_W-1:0]  set_q;
    logic              decode_q, rd_set_q, rd_mem_q, lookup_q, process_q, update_q;
    logic              abort_q, err_q;
    logic [31:0]       txn_q;

    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] grant_c;
    logic [CH_W-1:0]   win_c;
    logic              any_c;
    logic              adv_c;

    assign elig_c = bus.in_valid & ~bus.stall_mask;
    assign adv_c  = (state == ST_DECODE) && any_c;

    llc_rr_arbiter #(.N(NUM_CH), .IW(CH_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig_c),
        .rr_mode   (bus.rr_mode),
        .advance   (adv_c),
        .grant     (grant_c),
        .grant_idx (win_c),
        .any       (any_c)
    );

    // Stage FSM with the enables registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_DECODE;
            decode_q  <= 1'b1;
            rd_set_q  <= 1'b0;
            rd_mem_q  <= 1'b0;
            lookup_q  <= 1'b0;
            process_q <= 1'b0;
            update_q  <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
            txn_q     <= '0;
            grant_q   <= '0;
            set_q     <= '0;
            rd_cnt    <= '0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                ST_DECODE: begin
                    if (any_c) begin
                        state    <= ST_READ_SET;
                        decode_q <= 1'b0;
                        rd_set_q <= 1'b1;
                        grant_q  <= win_c;
                        set_q    <= bus.in_set[win_c];
                    end
                end
                ST_READ_SET: begin
                    state    <= ST_READ_MEM;
                    rd_set_q <= 1'b0;
                    rd_mem_q <= 1'b1;
                    rd_cnt   <= '0;
                end
                ST_READ_MEM: begin
                    if (rd_cnt == RD_W'(RD_LAT - 1)) begin
                        state     <= ST_LOOKUP;
                        rd_mem_q  <= 1'b0;
                        lookup_q  <= 1'b1;
                        process_q <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt + RD_W'(1);
                    end
                end
                ST_LOOKUP: begin
                    state    <= ST_PROCESS;
                    lookup_q <= 1'b0;
                    wd_cnt   <= '0;
                end
                ST_PROCESS: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // A done arriving on the expiry cycle wins over the watchdog.
                    if (bus.process_done || wd_cnt == WD_LAST) begin
                        state     <= ST_UPDATE;
                        process_q <= 1'b0;
                        update_q  <= 1'b1;
                        abort_q   <= ~bus.process_done;
                        err_q     <= err_q | ~bus.process_done;
                    end
                end
                ST_UPDATE: begin
                    state    <= ST_DECODE;
                    update_q <= 1'b0;
                    decode_q <= 1'b1;
                    abort_q  <= 1'b0;
                    txn_q    <= txn_q + 32'd1;
                end
                default: begin
                    state <= ST_DECODE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == ST_DECODE) ? grant_c : '0;
    assign bus.grant_ch    = grant_q;
    assign bus.set_out     = set_q;
    assign bus.decode_en   = decode_q;
    assign bus.rd_set_en   = rd_set_q;
    assign bus.rd_mem_en   = rd_mem_q;
    assign bus.lookup_en   = lookup_q;
    assign bus.process_en  = process_q;
    assign bus.update_en   = update_q;
    assign bus.abort       = abort_q;
    assign bus.err_timeout = err_q;
    assign bus.txn_cnt     = txn_q;

endmodule

// File: tb/tb_llc_txn_sequencer.sv
// Directed self-checking bench for llc_txn_sequencer (RD_LAT=1/WD_W=4 and RD_LAT=4 instances).
module tb_llc_txn_sequencer;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   exp_txn_a;

    llc_txn_sequencer_if #(.NUM_CH(4), .SET_W(9)) ifa ();
    llc_txn_sequencer_if #(.NUM_CH(4), .SET_W(9)) ifb ();

    llc_txn_sequencer #(.NUM_CH(4), .RD_LAT(1), .SET_W(9), .WD_W(4)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    llc_txn_sequencer #(.NUM_CH(4), .RD_LAT(4), .SET_W(9), .WD_W(10)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dec_a();
        int g = 0;
        while (ifa.decode_en !== 1'b1 && g < 60) begin
            tick();
            g++;
        end
    endtask

    // One grant on instance A with process_done held high: returns the DECODE in_ready and the registered channel.
    task automatic run_txn_a(output logic [3:0] rdy, output logic [1:0] gch);
        wait_dec_a();
        #1;
        rdy = ifa.in_ready;
        tick();
        gch = ifa.grant_ch;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (ifa.decode_en !== 1'b1) $display("FAIL reset_decode_en: got %b need 1", ifa.decode_en); else pass_cnt++;
        total_cnt++; if ({ifa.rd_set_en, ifa.rd_mem_en, ifa.lookup_en, ifa.process_en, ifa.update_en} !== 5'b0)
            $display("FAIL reset_enables: got %b need 00000", {ifa.rd_set_en, ifa.rd_mem_en, ifa.lookup_en, ifa.process_en, ifa.update_en}); else pass_cnt++;
        total_cnt++; if (ifa.in_ready !== 4'b0) $display("FAIL reset_in_ready: got %b need 0000", ifa.in_ready); else pass_cnt++;
        total_cnt++; if ({ifa.grant_ch, ifa.set_out} !== 11'h0) $display("FAIL reset_grant_set: got %h need 0", {ifa.grant_ch, ifa.set_out}); else pass_cnt++;
        total_cnt++; if ({ifa.abort, ifa.err_timeout} !== 2'b00) $display("FAIL reset_flags: got %b need 00", {ifa.abort, ifa.err_timeout}); else pass_cnt++;
        total_cnt++; if (ifa.txn_cnt !== 32'd0) $display("FAIL reset_txn_cnt: got %0d need 0", ifa.txn_cnt); else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_baseline();
        ifa.rr_mode = 1'b0; ifa.stall_mask = '0; ifa.process_done = 1'b0;
        ifa.in_set[2] = 9'h1A5; ifa.in_valid = 4'b0100;
        #1;
        total_cnt++; if (ifa.in_ready !== 4'b0100) $display("FAIL base_in_ready: got %b need 0100", ifa.in_ready); else pass_cnt++;
        tick();
        ifa.in_valid = '0;
        total_cnt++; if (ifa.in_ready !== 4'b0000) $display("FAIL base_ready_drop: got %b need 0000", ifa.in_ready); else pass_cnt++;
        total_cnt++; if (ifa.grant_ch !== 2'd2) $display("FAIL base_grant_ch: got %0d need 2", ifa.grant_ch); else pass_cnt++;
        total_cnt++; if (ifa.set_out !== 9'h1A5) $display("FAIL base_set_out: got %h need 1a5", ifa.set_out); else pass_cnt++;
        total_cnt++; if (ifa.rd_set_en !== 1'b1) $display("FAIL base_rd_set_en: got %b need 1", ifa.rd_set_en); else pass_cnt++;
        tick(); // READ_MEM
        total_cnt++; if (ifa.rd_mem_en !== 1'b1) $display("FAIL base_rd_mem_en: got %b need 1", ifa.rd_mem_en); else pass_cnt++;
        tick(); // LOOKUP
        total_cnt++; if ({ifa.lookup_en, ifa.process_en} !== 2'b11) $display("FAIL base_lookup: got %b need 11", {ifa.lookup_en, ifa.process_en}); else pass_cnt++;
        tick(); // PROCESS 1
        tick(); // PROCESS 2
        ifa.process_done = 1'b1;
        total_cnt++; if ({ifa.process_en, ifa.update_en} !== 2'b10) $display("FAIL base_process2: got %b need 10", {ifa.process_en, ifa.update_en}); else pass_cnt++;
        tick(); // UPDATE
        ifa.process_done = 1'b0;
        total_cnt++; if ({ifa.update_en, ifa.abort, ifa.decode_en} !== 3'b100) $display("FAIL base_update: got %b need 100", {ifa.update_en, ifa.abort, ifa.decode_en}); else pass_cnt++;
        tick(); // DECODE, 6 edges after accept
        exp_txn_a++;
        total_cnt++; if (ifa.decode_en !== 1'b1) $display("FAIL base_return_decode: got %b need 1", ifa.decode_en); else pass_cnt++;
        total_cnt++; if (ifa.txn_cnt !== 32'(exp_txn_a)) $display("FAIL base_txn_cnt: got %0d need %0d", ifa.txn_cnt, exp_txn_a); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] rdy;
        logic [1:0] gch;
        logic [3:0] oh;
        int         ch;
        ifa.rr_mode = 1'b1; ifa.process_done = 1'b1; ifa.in_valid = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            ch = (i % 3) + 1;
            oh = 4'b0001 << ch;
            run_txn_a(rdy, gch);
            exp_txn_a++;
            total_cnt++; if (rdy !== oh) $display("FAIL rr_ready_%0d: got %b need %b", i, rdy, oh); else pass_cnt++;
            total_cnt++; if (gch !== 2'(ch)) $display("FAIL rr_grant_%0d: got %0d need %0d", i, gch, ch); else pass_cnt++;
        end
        ifa.in_valid = 4'b1111;
        run_txn_a(rdy, gch);
        exp_txn_a++;
        total_cnt++; if (rdy !== 4'b0001) $display("FAIL rr_ch0_ready: got %b need 0001", rdy); else pass_cnt++;
        total_cnt++; if (gch !== 2'd0) $display("FAIL rr_ch0_grant: got %0d need 0", gch); else pass_cnt++;
        ifa.in_valid = 4'b1110;
        run_txn_a(rdy, gch);
        exp_txn_a++;
        total_cnt++; if (gch !== 2'd1) $display("FAIL rr_ptr_kept: got %0d need 1", gch); else pass_cnt++;
        ifa.in_valid = '0;
        wait_dec_a();
        total_cnt++; if (ifa.txn_cnt !== 32'(exp_txn_a)) $display("FAIL rr_txn_cnt: got %0d need %0d", ifa.txn_cnt, exp_txn_a); else pass_cnt++;
    endtask

    task automatic test_fixed_stall();
        logic [3:0] rdy;
        logic [1:0] gch;
        ifa.rr_mode = 1'b0; ifa.process_done = 1'b1;
        ifa.in_valid = 4'b1100; ifa.stall_mask = 4'b0100;
        run_txn_a(rdy, gch);
        exp_txn_a++;
        total_cnt++; if (rdy !== 4'b1000) $display("FAIL fix_stall_ready: got %b need 1000", rdy); else pass_cnt++;
        total_cnt++; if (gch !== 2'd3) $display("FAIL fix_stall_grant: got %0d need 3", gch); else pass_cnt++;
        ifa.stall_mask = '0;
        run_txn_a(rdy, gch);
        exp_txn_a++;
        total_cnt++; if (rdy !== 4'b0100) $display("FAIL fix_unstall_ready: got %b need 0100", rdy); else pass_cnt++;
        total_cnt++; if (gch !== 2'd2) $display("FAIL fix_unstall_grant: got %0d need 2", gch); else pass_cnt++;
        ifa.in_valid = '0;
        wait_dec_a();
        total_cnt++; if (ifa.txn_cnt !== 32'(exp_txn_a)) $display("FAIL fix_txn_cnt: got %0d need %0d", ifa.txn_cnt, exp_txn_a); else pass_cnt++;
    endtask

    task automatic test_read_latency();
        int rd_n = 0, lk_n = 0, lkp_n = 0, lk_idx = -1, last_rd = -1;
        ifb.rr_mode = 1'b0; ifb.stall_mask = '0; ifb.process_done = 1'b1;
        ifb.in_set[0] = 9'h055; ifb.in_valid = 4'b0001;
        #1;
        total_cnt++; if (ifb.in_ready !== 4'b0001) $display("FAIL lat_in_ready: got %b need 0001", ifb.in_ready); else pass_cnt++;
        tick();
        ifb.in_valid = '0;
        for (int i = 0; i < 12; i++) begin
            if (ifb.rd_mem_en === 1'b1) begin rd_n++; last_rd = i; end
            if (ifb.lookup_en === 1'b1) begin
                lk_n++; lk_idx = i;
                if (ifb.process_en === 1'b1) lkp_n++;
            end
            tick();
        end
        total_cnt++; if (rd_n !== 4) $display("FAIL lat_rd_mem_cycles: got %0d need 4", rd_n); else pass_cnt++;
        total_cnt++; if (lk_n !== 1 || lkp_n !== 1) $display("FAIL lat_lookup_cycles: got %0d/%0d need 1/1", lk_n, lkp_n); else pass_cnt++;
        total_cnt++; if (lk_idx !== 5 || last_rd !== 4) $display("FAIL lat_lookup_pos: got %0d/%0d need 5/4", lk_idx, last_rd); else pass_cnt++;
        total_cnt++; if (ifb.set_out !== 9'h055 || ifb.txn_cnt !== 32'd1) $display("FAIL lat_result: got %h/%0d need 055/1", ifb.set_out, ifb.txn_cnt); else pass_cnt++;
    endtask

    task automatic test_watchdog();
        int pc, g;
        ifa.rr_mode = 1'b0; ifa.stall_mask = '0; ifa.process_done = 1'b0;
        ifa.in_set[2] = 9'h033; ifa.in_valid = 4'b0100;
        wait_dec_a(); tick();
        ifa.in_valid = '0;
        pc = 0; g = 0;
        while (ifa.update_en !== 1'b1 && g < 60) begin
            if (ifa.process_en === 1'b1 && ifa.lookup_en !== 1'b1) pc++;
            tick(); g++;
        end
        total_cnt++; if (pc !== 15) $display("FAIL wd_process_cycles: got %0d need 15", pc); else pass_cnt++;
        total_cnt++; if ({ifa.abort, ifa.err_timeout} !== 2'b11) $display("FAIL wd_abort_flags: got %b need 11", {ifa.abort, ifa.err_timeout}); else pass_cnt++;
        tick();
        exp_txn_a++;
        total_cnt++; if (ifa.txn_cnt !== 32'(exp_txn_a)) $display("FAIL wd_txn_cnt: got %0d need %0d", ifa.txn_cnt, exp_txn_a); else pass_cnt++;
        total_cnt++; if ({ifa.decode_en, ifa.abort, ifa.err_timeout} !== 3'b101) $display("FAIL wd_after: got %b need 101", {ifa.decode_en, ifa.abort, ifa.err_timeout}); else pass_cnt++;

        ifa.in_valid = 4'b0100;
        wait_dec_a(); tick();
        ifa.in_valid = '0;
        pc = 0; g = 0;
        while (ifa.update_en !== 1'b1 && g < 60) begin
            if (ifa.process_en === 1'b1 && ifa.lookup_en !== 1'b1) begin
                pc++;
                if (pc == 15) ifa.process_done = 1'b1;
            end
            tick(); g++;
        end
        ifa.process_done = 1'b0;
        total_cnt++; if (pc !== 15) $display("FAIL wd_tie_cycles: got %0d need 15", pc); else pass_cnt++;
        total_cnt++; if ({ifa.abort, ifa.err_timeout} !== 2'b01) $display("FAIL wd_tie_flags: got %b need 01", {ifa.abort, ifa.err_timeout}); else pass_cnt++;
        tick();
        exp_txn_a++;
        total_cnt++; if (ifa.txn_cnt !== 32'(exp_txn_a)) $display("FAIL wd_tie_txn_cnt: got %0d need %0d", ifa.txn_cnt, exp_txn_a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ifa.process_done = 1'b0; ifa.in_set[2] = 9'h0F3; ifa.in_valid = 4'b0100;
        wait_dec_a(); tick();
        ifa.in_valid = '0;
        tick(); // READ_MEM
        total_cnt++; if (ifa.rd_mem_en !== 1'b1) $display("FAIL rstmid_in_read_mem: got %b need 1", ifa.rd_mem_en); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if ({ifa.decode_en, ifa.rd_mem_en, ifa.update_en} !== 3'b100) $display("FAIL rstmid_state: got %b need 100", {ifa.decode_en, ifa.rd_mem_en, ifa.update_en}); else pass_cnt++;
        total_cnt++; if ({ifa.grant_ch, ifa.set_out} !== 11'h0) $display("FAIL rstmid_grant_set: got %h need 0", {ifa.grant_ch, ifa.set_out}); else pass_cnt++;
        total_cnt++; if ({ifa.abort, ifa.err_timeout} !== 2'b00) $display("FAIL rstmid_flags: got %b need 00", {ifa.abort, ifa.err_timeout}); else pass_cnt++;
        total_cnt++; if (ifa.txn_cnt !== 32'd0) $display("FAIL rstmid_txn_cnt: got %0d need 0", ifa.txn_cnt); else pass_cnt++;
        total_cnt++; if (ifa.in_ready !== 4'b0000) $display("FAIL rstmid_in_ready: got %b need 0000", ifa.in_ready); else pass_cnt++;
        #2 rst = 1'b1;
        tick(); tick();
        total_cnt++; if ({ifa.decode_en, ifa.txn_cnt} !== {1'b1, 32'd0}) $display("FAIL rstmid_idle: got %b/%0d need 1/0", ifa.decode_en, ifa.txn_cnt); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; exp_txn_a = 0;
        ifa.in_valid = '0; ifa.in_set = '0; ifa.stall_mask = '0; ifa.rr_mode = 1'b0; ifa.process_done = 1'b0;
        ifb.in_valid = '0; ifb.in_set = '0; ifb.stall_mask = '0; ifb.rr_mode = 1'b0; ifb.process_done = 1'b0;
        test_reset();
        test_baseline();
        test_round_robin();
        test_fixed_stall();
        test_read_latency();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
